// File: rtl/cpu_freq_capture_pio.sv
// cpu_freq_capture_pio
// Multi-channel Avalon-MM input port for frequency-measurement results.
// Each channel delivers a DATA_W-bit value with a one-cycle valid strobe.
// The block keeps sticky per-channel "new" flags and takes atomic snapshots
// of all channels, triggered by software or automatically on any valid.
// It also raises a maskable interrupt.
//
// Optional build macro: FREQ_CAP_TIMESTAMP_EN
//   When this macro is defined, a free-running 32-bit cycle counter is built.
//   Every snapshot captures it into TIMESTAMP, which is read at word
//   address 4+CHANNELS. When the macro is undefined, that address reads 0.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   address     Avalon word address
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   32-bit write data
//   readdata    registered read data, one-cycle latency, no read strobe
//   in_data     packed channel values, channel i at [i*DATA_W +: DATA_W]
//   in_valid    per-channel one-cycle "new value" strobe
//   irq         registered interrupt, |(STATUS & IRQ_MASK)
//
// Register map (word addresses):
//   0 STATUS (W1C)   1 IRQ_MASK   2 CONTROL {AUTO, SNAP}   3 SNAP_COUNT
//   4+i SNAP_DATA[i] 4+CHANNELS TIMESTAMP (optional)       others read 0
module cpu_freq_capture_pio #(
  parameter int CHANNELS = 4,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            address,
  input  logic                         chipselect,
  input  logic                         write_n,
  input  logic [31:0]                  writedata,
  output logic [31:0]                  readdata,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  input  logic [CHANNELS-1:0]          in_valid,
  output logic                         irq
);

  localparam logic [31:0] ADDR_STATUS = 32'd0;
  localparam logic [31:0] ADDR_MASK   = 32'd1;
  localparam logic [31:0] ADDR_CTRL   = 32'd2;
  localparam logic [31:0] ADDR_CNT    = 32'd3;
`ifdef FREQ_CAP_TIMESTAMP_EN
  localparam logic [31:0] ADDR_TS     = 32'(4 + CHANNELS);
`endif

  logic [31:0]         addr_ext;
  logic                wr;
  logic                wr_status;
  logic                wr_mask;
  logic                wr_ctrl;
  logic                snap_fire;
  logic [CHANNELS-1:0] status;
  logic [CHANNELS-1:0] status_nxt;
  logic [CHANNELS-1:0] mask;
  logic [CHANNELS-1:0] mask_nxt;
  logic                auto_en;
  logic [CNT_W-1:0]    snap_cnt;
  logic [DATA_W-1:0]   snap_data [CHANNELS];
  logic [31:0]         rd_mux;
`ifdef FREQ_CAP_TIMESTAMP_EN
  logic [31:0]         ts_cnt;
  logic [31:0]         ts_snap;
`endif

  assign addr_ext  = 32'(address);
  assign wr        = chipselect & ~write_n;
  assign wr_status = wr && (addr_ext == ADDR_STATUS);
  assign wr_mask   = wr && (addr_ext == ADDR_MASK);
  assign wr_ctrl   = wr && (addr_ext == ADDR_CTRL);

  // Software and auto triggers in the same cycle merge into one snapshot.
  assign snap_fire = (wr_ctrl & writedata[0]) | (auto_en & (|in_valid));

  // The snapshot clears all flags, and W1C clears selected flags.
  // New strobes in this cycle are applied last, so a set always wins.
  always_comb begin
    status_nxt = status;
    if (wr_status) status_nxt = status_nxt & ~writedata[CHANNELS-1:0];
    if (snap_fire) status_nxt = '0;
    status_nxt = status_nxt | in_valid;
    mask_nxt   = wr_mask ? writedata[CHANNELS-1:0] : mask;
  end

  always_comb begin
    rd_mux = '0;
    if (addr_ext == ADDR_STATUS)    rd_mux = 32'(status);
    else if (addr_ext == ADDR_MASK) rd_mux = 32'(mask);
    else if (addr_ext == ADDR_CTRL) rd_mux = {30'd0, auto_en, 1'b0};
    else if (addr_ext == ADDR_CNT)  rd_mux = 32'(snap_cnt);
`ifdef FREQ_CAP_TIMESTAMP_EN
    else if (addr_ext == ADDR_TS)   rd_mux = ts_snap;
`endif
    for (int i = 0; i < CHANNELS; i++) begin
      if (addr_ext == 32'(4 + i)) rd_mux = 32'(snap_data[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status   <= '0;
      mask     <= '0;
      auto_en  <= 1'b0;
      snap_cnt <= '0;
      readdata <= '0;
      irq      <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) snap_data[i] <= '0;
    end else begin
      status   <= status_nxt;
      mask     <= mask_nxt;
      readdata <= rd_mux;
      // irq follows the next-state flags so it rises with the flag itself.
      irq      <= |(status_nxt & mask_nxt);
      if (wr_ctrl) auto_en <= writedata[1];
      if (snap_fire) begin
        snap_cnt <= snap_cnt + CNT_W'(1);
        for (int i = 0; i < CHANNELS; i++)
          snap_data[i] <= in_data[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef FREQ_CAP_TIMESTAMP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_cnt  <= '0;
      ts_snap <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (snap_fire) ts_snap <= ts_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_freq_capture_pio.sv
// Self-checking bench for cpu_freq_capture_pio (4 channels, 4-bit counter).
// A register-level model tracks the documented behaviour and is compared
// against readdata/irq on every falling edge. Directed sequences carry
// literal expectations, and a random phase then exercises the whole map.
module tb_cpu_freq_capture_pio;

  localparam int CH = 4;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [AW-1:0]     address = '0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic [CH*DW-1:0]  in_data = '0;
  logic [CH-1:0]     in_valid = '0;
  logic              irq;

  int n_checks = 0;
  int n_errors = 0;

  cpu_freq_capture_pio #(
    .CHANNELS(CH), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_data(in_data), .in_valid(in_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_status, m_mask, m_auto, m_cnt;
  logic [31:0] m_snap [CH];
  logic [31:0] m_ts, m_ts_snap, m_rd;
  logic        m_irq;
  bit          m_wr, m_trig;
  int          m_a;

  function automatic logic [31:0] model_read(input int a);
    if (a == 0) return 32'(m_status);
    if (a == 1) return 32'(m_mask);
    if (a == 2) return 32'(m_auto * 2);
    if (a == 3) return 32'(m_cnt);
    if (a >= 4 && a < 4 + CH) return m_snap[a-4];
`ifdef FREQ_CAP_TIMESTAMP_EN
    if (a == 4 + CH) return m_ts_snap;
`endif
    return 32'd0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_status = 0; m_mask = 0; m_auto = 0; m_cnt = 0;
      m_ts = 0; m_ts_snap = 0; m_rd = 0; m_irq = 0;
      for (int i = 0; i < CH; i++) m_snap[i] = 0;
    end else begin
      m_wr = chipselect && !write_n;
      m_a  = int'(address);
      m_rd = model_read(m_a);
      m_trig = (m_wr && m_a == 2 && writedata[0]) || (m_auto == 1 && in_valid != 0);
      if (m_wr && m_a == 0) m_status = m_status & ~int'(writedata[CH-1:0]);
      if (m_wr && m_a == 1) m_mask = int'(writedata[CH-1:0]);
      if (m_wr && m_a == 2) m_auto = int'(writedata[1]);
      if (m_trig) begin
        m_status = 0;
        for (int i = 0; i < CH; i++) m_snap[i] = in_data[i*DW +: DW];
        m_cnt = (m_cnt + 1) % (1 << CW);
        m_ts_snap = m_ts;
      end
      m_status = m_status | int'(in_valid);
      m_irq = (m_status & m_mask) != 0;
      m_ts = m_ts + 1;
    end
  end

  always @(negedge clk) begin
    check("readdata_vs_model", readdata, m_rd);
    check("irq_vs_model", {31'd0, irq}, {31'd0, m_irq});
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [CH-1:0] v = '0);
    chipselect = 1'b1; write_n = 1'b0; address = AW'(a); writedata = d; in_valid = v;
    step();
    chipselect = 1'b0; write_n = 1'b1; in_valid = '0;
  endtask

  task automatic rd(input int a, input logic [31:0] exp, input string name);
    chipselect = 1'b1; write_n = 1'b1; address = AW'(a);
    step();
    check(name, readdata, exp);
    chipselect = 1'b0;
  endtask

  logic [31:0] t1, t2;

  initial begin
    repeat (3) step();
    check("reset_readdata", readdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    step();

    // Flag, interrupt, clear, and set-wins conflict
    wr(1, 32'h2);
    address = '0; in_valid = 4'b0010;
    step();
    in_valid = '0;
    check("irq_rise", {31'd0, irq}, 32'd1);
    rd(0, 32'h2, "status_set");
    wr(0, 32'h2);
    check("irq_drop_on_clear", {31'd0, irq}, 32'd0);
    wr(0, 32'h2, 4'b0010);
    check("irq_set_wins", {31'd0, irq}, 32'd1);
    rd(0, 32'h2, "status_set_wins");

    // Software snapshot
    in_data = {32'h44, 32'h33, 32'h22, 32'h11};
    wr(2, 32'h1);
    for (int i = 0; i < CH; i++) in_data[i*DW +: DW] = $urandom;
    rd(4, 32'h11, "snap_ch0");
    rd(5, 32'h22, "snap_ch1");
    rd(6, 32'h33, "snap_ch2");
    rd(7, 32'h44, "snap_ch3");
    rd(3, 32'd1, "snap_count_1");
    rd(0, 32'h0, "status_cleared_by_snap");
    rd(2, 32'h0, "control_reads_0");

    // Auto snapshot, then a merged software and auto trigger
    wr(2, 32'h2);
    rd(2, 32'h2, "auto_readback");
    in_data[2*DW +: DW] = 32'hABCD; in_valid = 4'b0100;
    step();
    in_valid = '0;
    rd(6, 32'hABCD, "auto_snap_ch2");
    rd(3, 32'd2, "auto_snap_count");
    rd(0, 32'h4, "auto_status");
    wr(2, 32'h3, 4'b0001);
    rd(3, 32'd3, "merged_trigger_count");

    // Counter wrap after 16 total snapshots
    for (int i = 0; i < 13; i++) wr(2, 32'h3);
    rd(3, 32'd0, "count_wrap");
    rd(15, 32'd0, "unmapped_reads_0");
    wr(3, 32'h5);
    rd(3, 32'd0, "ro_count_write_ignored");

`ifdef FREQ_CAP_TIMESTAMP_EN
    wr(2, 32'h1);
    address = AW'(8); chipselect = 1'b1; step(); t1 = readdata; chipselect = 1'b0;
    repeat (98) step();
    wr(2, 32'h1);
    address = AW'(8); chipselect = 1'b1; step(); t2 = readdata; chipselect = 1'b0;
    check("timestamp_delta", t2 - t1, 32'd100);
`else
    rd(8, 32'd0, "timestamp_absent_reads_0");
`endif

    // Randomised phase
    for (int n = 0; n < 600; n++) begin
      address    = AW'($urandom_range(0, 15));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 3) != 0);
      writedata  = $urandom;
      in_valid   = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '0;
      for (int i = 0; i < CH; i++) in_data[i*DW +: DW] = $urandom;
      step();
    end
    chipselect = 1'b0; write_n = 1'b1; in_valid = '0;

    // Reset mid-operation with all flags pending
    wr(1, 32'hF);
    in_valid = 4'hF;
    step();
    in_valid = '0;
    check("pre_reset_irq", {31'd0, irq}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_reset_readdata", readdata, 32'd0);
    check("async_reset_irq", {31'd0, irq}, 32'd0);
    step();
    step();
    reset = 1'b0;
    for (int a = 0; a < 8; a++) rd(a, 32'd0, $sformatf("post_reset_addr%0d", a));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_freq_capture_pio.md
Name: cpu_freq_capture_pio

Overview:
Parametrised multi-channel Avalon-MM input port for frequency-measurement results. It succeeds the single 32-bit read-only PIO. Each channel carries a DATA_W-bit measurement and a one-cycle valid strobe from fabric counters. The block keeps sticky per-channel "new" flags, takes atomic snapshots of all channels (software- or auto-triggered), and raises a maskable interrupt to the Nios CPU.

Parameters:
CHANNELS, 4, number of measurement channels; legal range 1..16.
DATA_W, 32, width of each channel value; legal range 1..32; zero-extended onto readdata.
ADDR_W, 4, word-address width; must satisfy 2^ADDR_W >= 5+CHANNELS.
CNT_W, 16, width of the snapshot counter; legal range 1..32.

Ports:
clk  in  1  system clock; sole clock.
reset  in  1  asynchronous, active-high reset.
address  in  ADDR_W  Avalon word address.
chipselect  in  1  slave select.
write_n  in  1  active-low write strobe.
writedata  in  32  write data.
readdata  out  32  registered read data.
in_data  in  CHANNELS*DATA_W  channel values; channel i occupies bits [i*DATA_W +: DATA_W]; synchronous to clk.
in_valid  in  CHANNELS  one-cycle strobe per channel: new value present on in_data.
irq  out  1  registered interrupt, active high.

Behaviour:
- Reset: asynchronous assert, synchronous release. While reset is high, the following are all 0: readdata, irq, STATUS, IRQ_MASK, AUTO, snapshot registers, snapshot counter, timestamp.
- Write: occurs when chipselect=1 and write_n=0. Writes to read-only or unmapped addresses are ignored.
- Register map (word addresses):
  - 0 STATUS: read returns sticky new flags in [CHANNELS-1:0]. Write-1-to-clear.
  - 1 IRQ_MASK: RW in [CHANNELS-1:0].
  - 2 CONTROL: bit0 SNAP is write-only and self-clearing; it reads 0. bit1 AUTO is RW.
  - 3 SNAP_COUNT: RO, CNT_W bits, zero-extended.
  - 4+i SNAP_DATA[i]: RO, snapshot of channel i.
  - 4+CHANNELS TIMESTAMP: only with the optional feature; otherwise reads 0.
  - All other addresses read 0.
- Read path: readdata is updated every cycle from the address mux, with no read strobe. The value at address A in cycle T is visible on readdata in cycle T+1 (one-cycle latency).
- Flag set: in_valid[i]=1 sets STATUS[i] at the next edge.
- Flag clear: a write to STATUS with writedata[i]=1 clears STATUS[i].
- Flag conflict: if set and clear hit the same channel in the same cycle, set wins.
- Snapshot trigger: a snapshot fires in cycle T if either of the following holds:
  - a CONTROL write with writedata[0]=1 occurs in cycle T;
  - AUTO=1 and |in_valid=1 in cycle T.
- Snapshot action: at the edge closing cycle T, all SNAP_DATA[i] load in_data[i] as present in cycle T, atomically. The same edge increments SNAP_COUNT, which wraps from 2^CNT_W-1 to 0, and clears all STATUS flags except those set by in_valid in cycle T (set wins).
- Multiple triggers: a software and an auto trigger in the same cycle produce one snapshot and one count increment.
- CONTROL write: a write with bit0=1 also updates AUTO from bit1 in the same cycle. The new AUTO value first affects cycle T+1.
- irq: registered |(STATUS & IRQ_MASK), evaluated from the next-state values, so irq rises on the same edge the flag sets. It drops on the edge where the flag clears or the mask bit is written 0.
- Reset mid-operation: all state is discarded immediately, with no pending snapshot or interrupt. The first post-reset edge behaves as from a cold start.

Optional Feature:
Macro FREQ_CAP_TIMESTAMP_EN.
- Defined: a free-running 32-bit counter increments every clk and wraps. It is captured into a TIMESTAMP register by every snapshot, using the same edge and atomicity as SNAP_DATA, and is readable at address 4+CHANNELS.
- Undefined: no counter or register is built, and address 4+CHANNELS reads 0.

Test Plan:
1. Reset check: assert reset mid-run with STATUS=0xF and irq=1 -> readdata, irq, STATUS, SNAP_COUNT all 0 in the same cycle. Reads of addresses 0-7 return 0 after release.
2. Flag, interrupt and clear: IRQ_MASK=0x2; pulse in_valid[1] -> STATUS=0x2 and irq=1 at the next edge. Write STATUS=0x2 -> irq=0 at the next edge. Repeat with the clear and in_valid[1] in the same cycle -> STATUS stays 0x2 and irq stays 1.
3. Software snapshot: in_data ch0..3 = 0x11,0x22,0x33,0x44; write CONTROL=0x1 in cycle T -> reading addr 4..7 returns 0x11..0x44. SNAP_COUNT=1. Changing in_data afterwards does not alter reads.
4. Auto snapshot: AUTO=1; pulse in_valid[2] with ch2=0xABCD -> SNAP_DATA[2]=0xABCD, SNAP_COUNT+1, STATUS=0x4. Software and auto trigger in the same cycle -> SNAP_COUNT increments by exactly 1.
5. Counter wrap: CNT_W=4; 16 snapshots -> SNAP_COUNT reads 0. Read addr 15 -> 0. Write to addr 3 has no effect.
6. Timestamp (FREQ_CAP_TIMESTAMP_EN): two snapshots 100 cycles apart -> TIMESTAMP difference equals 100. Without the macro, addr 8 reads 0.
